div_share_ctrl: RTL and testbench
=================================

# div_share_ctrl

Sequenced, shared 4-bit ÷ 2-bit restoring divider with a two-requester round-robin arbiter. Each accepted request runs through one shift/compare/subtract step per cycle, four steps total. The result returns on a single tagged response channel with valid/ready backpressure. It sits between two client blocks and one divider step datapath, replacing per-client combinational dividers.

## Interface
- `DW`, 4: dividend, quotient and remainder width. Also the iteration count.
- `BW`, 2: divisor width.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` in 1, `req0_ready` out 1, `req0_a` in DW, `req0_b` in BW: requester 0 dividend/divisor.
- `req1_valid` in 1, `req1_ready` out 1, `req1_a` in DW, `req1_b` in BW: requester 1.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_id` out 1: index of the requester that owns the response.
- `rsp_quot` out DW: quotient.
- `rsp_rem` out DW: remainder.
- `rsp_dz` out 1: divisor was zero.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- **FSM states:** IDLE, ITER, DONE.
- **IDLE:**
  - Arbiter grants one requester.
  - `reqN_ready = (state==IDLE) & grantN`; combinational, and never high for both.
  - Handshake (valid & ready at edge) does the following:
    - loads `w = {DW'b0, a}` (2·DW bits) and `d = {b, DW'b0}` zero-extended to 2·DW;
    - captures id and dz = (b==0);
    - sets count = 0 and moves to ITER.
- **Arbitration:**
  - One requester valid: grant it.
  - Both valid: grant the one ≠ `last_id`.
  - `last_id` updates only on acceptance.
- **ITER step, one per cycle:**
  - `w' = w << 1`.
  - If `w' >= d`, then `w = w' - d + 1`; else `w = w'`.
  - count increments; after the DW-th step, go to DONE.
- **DONE:**
  - `rsp_valid` = 1.
  - `rsp_quot = w[DW-1:0]`, `rsp_rem = w[2DW-1:DW]`.
  - `rsp_id` and `rsp_dz` come from the captured values.
  - All outputs are held stable until `rsp_ready`; on the handshake edge, go to IDLE.
  - No new request is accepted in the DONE cycle.
- **Divide by zero:** not special-cased in the datapath. The step rule naturally yields quot = all ones and rem = a; `rsp_dz` flags it.
- **Inputs:** `reqN_a`/`reqN_b` are sampled only at the acceptance edge; later changes have no effect.
- **Registers:** all arithmetic is unsigned. `w` is exactly 2·DW bits; no carry is kept beyond it.
- **Reset values:**
  - state = IDLE, count = 0, w = 0, id = 0, dz = 0;
  - `last_id` = 1, so requester 0 wins the first tie;
  - `rsp_valid` = 0, `busy` = 0, `rsp_quot` = `rsp_rem` = 0.

## Timing
- Request accepted at edge E0 → state ITER during cycles 1–4 → `rsp_valid` high from cycle 5 (5 cycles after the acceptance cycle).
- Minimum spacing between acceptances: 6 cycles (accept, 4 ITER, DONE with `rsp_ready` = 1).
- `rsp_ready` held low: stay in DONE indefinitely with outputs unchanged. Requesters see ready = 0.
- A requester dropping valid before grant is allowed; no request is latched without a handshake.
- A losing requester keeps valid high and is granted at the next IDLE.
- `rst` asserted in any state, including mid-ITER or DONE with `rsp_valid` high:
  - next edge forces the reset values;
  - the in-flight request is discarded with no response;
  - ready stays 0 during the reset cycle.
- `rst` and `reqN_valid` in the same cycle: reset wins and no request is accepted.

## Test plan
- **Single request:** req0 a=13, b=3 → `rsp_valid` 5 cycles after accept, quot=4, rem=1, id=0, dz=0.
- **Edge values:**
  - a=15, b=1 → quot=15, rem=0.
  - a=0, b=2 → quot=0, rem=0.
  - a=9, b=0 → quot=15, rem=9, dz=1.
- **Tie after reset:** req0 (a=7, b=2) and req1 (a=11, b=3) valid the same cycle.
  - req0 is served first: quot=3, rem=1, id=0.
  - req1 is accepted next IDLE: quot=3, rem=2, id=1.
  - Next tie with fresh requests grants req0 again (alternation).
- **Backpressure:** hold `rsp_ready` = 0 for 4 cycles in DONE.
  - Outputs are stable and both readys stay 0.
  - Handshake occurs when `rsp_ready` rises; readys reassert the following cycle.
- **Reset mid-ITER:** assert `rst` on the 2nd ITER cycle of a=14, b=3.
  - `rsp_valid` never rises and `busy` drops next cycle.
  - A new request then completes normally.
- **Exhaustive sweep:** all 16×4 (a,b) pairs through both requesters. Check `quot*b + rem == a` and `rem < b` for b ≠ 0, and the dz rule for b = 0.

Source files
------------

// File: rtl/div_share_ctrl.sv
// Shared sequential restoring divider (DW-bit dividend / BW-bit divisor) fed by
// two requesters through a round-robin arbiter; one tagged response channel.
module div_share_ctrl #(
  parameter int DW = 4,
  parameter int BW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [BW-1:0] req0_b,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [BW-1:0] req1_b,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_quot,
  output logic [DW-1:0] rsp_rem,
  output logic          rsp_dz,
  output logic          busy
);

  localparam int WW = 2 * DW;
  localparam int CW = $clog2(DW) + 1;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] w_q, w_d;
  logic [WW-1:0] d_q, d_d;
  logic [CW-1:0] count_q, count_d;
  logic          id_q, id_d;
  logic          dz_q, dz_d;
  logic          last_id_q, last_id_d;

  logic          grant0, grant1;
  logic          accept0, accept1;
  logic [WW-1:0] w_shift;
  logic [WW-1:0] w_sub;

  // On a tie the requester that was not served last wins.
  assign grant0 = req0_valid & (~req1_valid | last_id_q);
  assign grant1 = req1_valid & (~req0_valid | ~last_id_q);

  // Ready is masked during reset so no request can slip in alongside it.
  assign req0_ready = (state_q == IDLE) & grant0 & ~rst;
  assign req1_ready = (state_q == IDLE) & grant1 & ~rst;
  assign accept0    = req0_valid & req0_ready;
  assign accept1    = req1_valid & req1_ready;

  assign w_shift = w_q << 1;
  assign w_sub   = w_shift - d_q + {{(WW-1){1'b0}}, 1'b1};

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    d_d       = d_q;
    count_d   = count_q;
    id_d      = id_q;
    dz_d      = dz_q;
    last_id_d = last_id_q;
    case (state_q)
      IDLE: begin
        if (accept0 || accept1) begin
          if (accept0) begin
            w_d  = {{DW{1'b0}}, req0_a};
            d_d  = {{(WW-DW-BW){1'b0}}, req0_b, {DW{1'b0}}};
            id_d = 1'b0;
            dz_d = (req0_b == '0);
          end else begin
            w_d  = {{DW{1'b0}}, req1_a};
            d_d  = {{(WW-DW-BW){1'b0}}, req1_b, {DW{1'b0}}};
            id_d = 1'b1;
            dz_d = (req1_b == '0);
          end
          last_id_d = accept1;
          count_d   = '0;
          state_d   = ITER;
        end
      end
      ITER: begin
        // A zero divisor always passes the compare, which yields all-ones / a.
        w_d     = (w_shift >= d_q) ? w_sub : w_shift;
        count_d = count_q + 1'b1;
        if (count_q == CW'(DW - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      w_q       <= '0;
      d_q       <= '0;
      count_q   <= '0;
      id_q      <= 1'b0;
      dz_q      <= 1'b0;
      last_id_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      d_q       <= d_d;
      count_q   <= count_d;
      id_q      <= id_d;
      dz_q      <= dz_d;
      last_id_q <= last_id_d;
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign rsp_quot  = w_q[DW-1:0];
  assign rsp_rem   = w_q[WW-1:DW];
  assign rsp_id    = id_q;
  assign rsp_dz    = dz_q;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for div_share_ctrl: scoreboard of expected quotient/remainder
// pushed at acceptance and compared when the response appears.
module tb_div_share_ctrl;

  localparam int DW = 4;
  localparam int BW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] req0_a = '0, req1_a = '0;
  logic [BW-1:0] req0_b = '0, req1_b = '0;
  logic          rsp_valid, rsp_id, rsp_dz, busy;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_quot, rsp_rem;

  typedef struct packed {
    logic          id;
    logic [DW-1:0] a;
    logic [BW-1:0] b;
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    logic          dz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  div_share_ctrl #(.DW(DW), .BW(BW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quot(rsp_quot), .rsp_rem(rsp_rem), .rsp_dz(rsp_dz), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic id, input logic [DW-1:0] a, input logic [BW-1:0] b);
    exp_t e;
    e.id = id;
    e.a  = a;
    e.b  = b;
    e.dz = (b == 0);
    e.q  = (b == 0) ? 4'hF : DW'(a / b);
    e.r  = (b == 0) ? a : DW'(a % b);
    sb.push_back(e);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 30) begin
      step();
      lat++;
    end
  endtask

  // Drive one request, wait for its grant, accept it, then check response latency.
  task automatic issue(input logic id, input logic [DW-1:0] a, input logic [BW-1:0] b);
    int n;
    int lat;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    #1;
    n = 0;
    while (!(id ? req1_ready : req0_ready) && n < 20) begin
      step();
      n++;
    end
    chk("grant_ready", id ? req1_ready : req0_ready, 1);
    push_exp(id, a, b);
    step();
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    wait_rsp(lat);
    chk("latency", lat, 5);
  endtask

  // Compare the current response against the scoreboard head, then handshake it.
  task automatic receive();
    exp_t e;
    chk("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_id", rsp_id, e.id);
      chk("rsp_quot", rsp_quot, e.q);
      chk("rsp_rem", rsp_rem, e.r);
      chk("rsp_dz", rsp_dz, e.dz);
      if (e.b != 0) begin
        chk("identity", int'(rsp_quot) * int'(e.b) + int'(rsp_rem), e.a);
        chk("rem_lt_b", rsp_rem < e.b, 1);
      end
      $display("txn id=%0d a=%0d b=%0d quot=%0d rem=%0d dz=%0d",
               rsp_id, e.a, e.b, rsp_quot, rsp_rem, rsp_dz);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("idle_after_rsp", busy, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] hold_q, hold_r;
    logic          hold_id, hold_dz, rose;
    int            lat;

    // Reset state, with a request pending that must not be granted.
    rst = 1'b1;
    req0_valid = 1'b1;
    step();
    step();
    chk("reset_ready0", req0_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_quot", rsp_quot, 0);
    chk("reset_rem", rsp_rem, 0);
    req0_valid = 1'b0;
    rst = 1'b0;
    step();

    // Single request and edge values.
    issue(0, 4'd13, 2'd3); receive();
    issue(0, 4'd15, 2'd1); receive();
    issue(0, 4'd0,  2'd2); receive();
    issue(1, 4'd9,  2'd0); receive();

    // Tie after reset: req0 first, then req1, then req0 again.
    do_reset();
    req0_valid = 1'b1; req0_a = 4'd7;  req0_b = 2'd2;
    req1_valid = 1'b1; req1_a = 4'd11; req1_b = 2'd3;
    #1;
    chk("tie1_ready0", req0_ready, 1);
    chk("tie1_ready1", req1_ready, 0);
    push_exp(0, 4'd7, 2'd2);
    step();
    req0_valid = 1'b0;
    wait_rsp(lat);
    chk("tie1_latency", lat, 5);
    chk("tie1_ready1_busy", req1_ready, 0);
    receive();
    chk("tie1_second_ready1", req1_ready, 1);
    issue(1, 4'd11, 2'd3); receive();
    req0_valid = 1'b1; req0_a = 4'd12; req0_b = 2'd1;
    req1_valid = 1'b1; req1_a = 4'd6;  req1_b = 2'd2;
    #1;
    chk("tie2_ready0", req0_ready, 1);
    chk("tie2_ready1", req1_ready, 0);
    issue(0, 4'd12, 2'd1); receive();
    issue(1, 4'd6, 2'd2); receive();

    // Backpressure: hold DONE for 4 cycles with a competing request waiting.
    issue(0, 4'd10, 2'd3);
    req1_valid = 1'b1; req1_a = 4'd5; req1_b = 2'd2;
    #1;
    hold_q = rsp_quot; hold_r = rsp_rem; hold_id = rsp_id; hold_dz = rsp_dz;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_valid", rsp_valid, 1);
      chk("bp_quot", rsp_quot, hold_q);
      chk("bp_rem", rsp_rem, hold_r);
      chk("bp_id", rsp_id, hold_id);
      chk("bp_dz", rsp_dz, hold_dz);
      chk("bp_readys", {req0_ready, req1_ready}, 0);
    end
    receive();
    chk("bp_ready_reassert", req1_ready, 1);
    issue(1, 4'd5, 2'd2); receive();

    // Reset on the second ITER cycle discards the in-flight request.
    req0_valid = 1'b1; req0_a = 4'd14; req0_b = 2'd3;
    #1;
    chk("mid_ready", req0_ready, 1);
    step();
    req0_valid = 1'b0;
    step();
    chk("mid_busy_before", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_busy_after", busy, 0);
    chk("mid_valid_after", rsp_valid, 0);
    rose = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (rsp_valid) rose = 1'b1;
    end
    chk("mid_no_rsp", rose, 0);
    issue(0, 4'd14, 2'd3); receive();

    // Exhaustive sweep through both requesters.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 4; b++) begin
        issue(0, DW'(a), BW'(b)); receive();
        issue(1, DW'(a), BW'(b)); receive();
      end
    end

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
